// File: rtl/sram_emu_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_emu_responder
// Purpose  : Block-RAM stand-in for an external async SRAM chip, sampled in
//            the controller clock domain.
// Revision : 1.0
// ============================================================================
module sram_emu_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [17:0]       ad,
    input  logic              we_n,
    input  logic              oe_n,
    input  logic              ce_n,
    input  logic              ub_n,
    input  logic              lb_n,
    inout  wire  [DATA_W-1:0] dio,
    output logic [15:0]       wr_count,
    output logic              conflict
);

    localparam int HALF = DATA_W / 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [ADDR_W-1:0] ad_q;
    logic              we_q, oe_q, ce_q, ub_q, lb_q;
    logic [DATA_W-1:0] din_q;
    logic              we_q2, oe_q2, ce_q2, ub_q2, lb_q2;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] data_w;
    logic              ub_w, lb_w;

    logic              wr_act;
    logic              commit;
    logic              wr_ending;
    logic              latch_en;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_next;
    logic [DATA_W-1:0] rd_q;
    logic              drv_ok;

    logic              unused_ad_hi;
    assign unused_ad_hi = ^ad[17:ADDR_W];

    // Input stage plus a second enable stage aligned with the RAM read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ad_q  <= '0;
            din_q <= '0;
            we_q  <= 1'b1;
            oe_q  <= 1'b1;
            ce_q  <= 1'b1;
            ub_q  <= 1'b1;
            lb_q  <= 1'b1;
            we_q2 <= 1'b1;
            oe_q2 <= 1'b1;
            ce_q2 <= 1'b1;
            ub_q2 <= 1'b1;
            lb_q2 <= 1'b1;
        end else begin
            ad_q  <= ad[ADDR_W-1:0];
            din_q <= dio;
            we_q  <= we_n;
            oe_q  <= oe_n;
            ce_q  <= ce_n;
            ub_q  <= ub_n;
            lb_q  <= lb_n;
            we_q2 <= we_q;
            oe_q2 <= oe_q;
            ce_q2 <= ce_q;
            ub_q2 <= ub_q;
            lb_q2 <= lb_q;
        end
    end

    assign wr_act = !ce_q && !we_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (wr_act) state_nxt = S_WRITE;
            S_WRITE:  if (!wr_act) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = wr_act ? S_WRITE : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        commit    = 1'b0;
        wr_ending = 1'b0;
        latch_en  = 1'b0;
        case (state)
            S_IDLE:   latch_en = wr_act;
            S_WRITE: begin
                latch_en  = wr_act;
                wr_ending = !wr_act;
            end
            S_COMMIT: begin
                commit   = 1'b1;
                latch_en = wr_act;
            end
            default: begin
                commit    = 1'b0;
                wr_ending = 1'b0;
                latch_en  = 1'b0;
            end
        endcase
    end

    // Sampling on entry too makes a single-cycle we_n pulse capture its data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_w <= '0;
            data_w <= '0;
            ub_w   <= 1'b1;
            lb_w   <= 1'b1;
        end else if (latch_en) begin
            addr_w <= ad_q;
            data_w <= din_q;
            ub_w   <= ub_q;
            lb_w   <= lb_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= 16'd0;
            conflict <= 1'b0;
        end else begin
            if (commit && !(ub_w && lb_w)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (wr_act && !oe_q) begin
                conflict <= 1'b1;
            end
        end
    end

    // Forward the finishing write (ending or committing) so a read issued right
    // after the we_n rising edge never returns the stale word.
    always_comb begin
        rd_next = mem[ad_q];
        if ((commit || wr_ending) && (addr_w == ad_q)) begin
            if (!ub_w) rd_next[DATA_W-1:HALF] = data_w[DATA_W-1:HALF];
            if (!lb_w) rd_next[HALF-1:0]      = data_w[HALF-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            if (!ub_w) mem[addr_w][DATA_W-1:HALF] <= data_w[DATA_W-1:HALF];
            if (!lb_w) mem[addr_w][HALF-1:0]      <= data_w[HALF-1:0];
        end
        rd_q <= rd_next;
    end

    // we_q also gates the drivers so the bus is released as soon as a write starts.
    assign drv_ok = !ce_q2 && !oe_q2 && we_q2 && we_q;

    assign dio[DATA_W-1:HALF] = (drv_ok && !ub_q2) ? rd_q[DATA_W-1:HALF] : {HALF{1'bz}};
    assign dio[HALF-1:0]      = (drv_ok && !lb_q2) ? rd_q[HALF-1:0]      : {HALF{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_emu_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_emu_responder
// Purpose  : Directed and random bus traffic against a word-level SRAM model.
// Revision : 1.0
// ============================================================================
module tb_sram_emu_responder;

    logic        clk;
    logic        reset_n;
    logic [17:0] ad;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;
    tri1  [15:0] dio;
    logic [15:0] wr_count;
    logic        conflict;

    logic        tb_drv_en;
    logic [15:0] tb_drv_val;
    assign dio = tb_drv_en ? tb_drv_val : 16'bz;

    sram_emu_responder #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ad       (ad),
        .we_n     (we_n),
        .oe_n     (oe_n),
        .ce_n     (ce_n),
        .ub_n     (ub_n),
        .lb_n     (lb_n),
        .dio      (dio),
        .wr_count (wr_count),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the memory as the controller sees it, updated once per write.
    logic [15:0] ref_mem [0:1023];
    logic [15:0] ref_cnt;
    logic        ref_conf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        we_n = 1'b1; oe_n = 1'b1; ce_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        tb_drv_en = 1'b0;
    endtask

    // Write pulse of plen cycles; only the final cycle's data counts.
    task automatic write_word(input logic [17:0] a, input logic [15:0] d,
                              input logic u, input logic l, input int plen,
                              input bit with_oe, input bit post_cycle, input bit ce_hold);
        ce_n = 1'b0; we_n = 1'b0; oe_n = with_oe ? 1'b0 : 1'b1;
        ad = a; ub_n = u; lb_n = l; tb_drv_en = 1'b1;
        for (int i = 0; i < plen; i++) begin
            tb_drv_val = (i == plen - 1) ? d : 16'($urandom);
            tick();
        end
        we_n = 1'b1; oe_n = 1'b1; tb_drv_en = 1'b0; ce_n = ce_hold ? 1'b0 : 1'b1;
        if (with_oe) ref_conf = 1'b1;
        if (!(u && l)) begin
            ref_cnt = ref_cnt + 16'd1;
            if (!u) ref_mem[a[9:0]][15:8] = d[15:8];
            if (!l) ref_mem[a[9:0]][7:0]  = d[7:0];
        end
        if (post_cycle) tick();
    endtask

    // Data 2 clocks after presenting the read; bus released 2 clocks after oe_n/ce_n rise.
    task automatic read_word(input string tag, input logic [17:0] a, input logic u, input logic l);
        logic [15:0] exp;
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; ad = a; ub_n = u; lb_n = l;
        tb_drv_en = 1'b0;
        tick();
        tick();
        @(negedge clk);
        exp[15:8] = u ? 8'hFF : ref_mem[a[9:0]][15:8];
        exp[7:0]  = l ? 8'hFF : ref_mem[a[9:0]][7:0];
        check_val(tag, dio, exp);
        ce_n = 1'b1; oe_n = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_val({tag, "_off"}, dio, 16'hFFFF);
        check_val({tag, "_cnt"}, wr_count, ref_cnt);
        check_val({tag, "_conf"}, {15'd0, conflict}, {15'd0, ref_conf});
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] prev20;
        bus_idle();
        ad = '0; tb_drv_val = '0;
        reset_n = 1'b0;
        ref_cnt = 16'd0; ref_conf = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        check_val("rst_cnt", wr_count, 16'd0);
        check_val("rst_conf", {15'd0, conflict}, 16'd0);
        check_val("rst_dio", dio, 16'hFFFF);
        #1;

        // Single write, then read-back
        write_word(18'h00012, 16'hA55A, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        read_word("single", 18'h00012, 1'b0, 1'b0);

        // Give every low address a known value
        for (int i = 0; i < 64; i++)
            write_word(18'(i), 16'($urandom), 1'b0, 1'b0, 1, 1'b0, 1'b1, ($urandom_range(0, 1) == 1));
        tick(); tick();

        // Byte lanes
        write_word(18'h5, 16'h1234, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        write_word(18'h5, 16'hFFFF, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        read_word("lane_full", 18'h5, 1'b0, 1'b0);
        read_word("lane_hi", 18'h5, 1'b0, 1'b1);

        // Aliased write with the read presented immediately afterwards
        write_word(18'h3, 16'h1234, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        write_word(18'h00403, 16'hBEEF, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        read_word("bypass", 18'h00003, 1'b0, 1'b0);

        // Back-to-back writes, then one with both lanes disabled
        write_word(18'h1, 16'h0001, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1);
        write_word(18'h2, 16'h0002, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1);
        write_word(18'h3, 16'h0003, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        read_word("b2b_1", 18'h1, 1'b0, 1'b0);
        read_word("b2b_2", 18'h2, 1'b0, 1'b0);
        read_word("b2b_3", 18'h3, 1'b0, 1'b0);
        write_word(18'h4, 16'h4444, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        read_word("nolane", 18'h4, 1'b0, 1'b0);

        // Conflict: we_n, oe_n, ce_n all low for one cycle
        write_word(18'h9, 16'h7777, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("conf_dio", dio, 16'hFFFF);
            #1;
        end
        read_word("conf_rd", 18'h9, 1'b0, 1'b0);

        // Reset in the middle of a write pulse
        prev20 = ref_mem[10'h20];
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ad = 18'h20; ub_n = 1'b0; lb_n = 1'b0;
        tb_drv_en = 1'b1; tb_drv_val = 16'hDEAD;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        bus_idle();
        reset_n = 1'b1;
        ref_cnt = 16'd0; ref_conf = 1'b0;
        tick(); tick(); tick(); tick();
        @(negedge clk);
        check_val("mrst_cnt", wr_count, 16'd0);
        check_val("mrst_conf", {15'd0, conflict}, 16'd0);
        check_val("mrst_dio", dio, 16'hFFFF);
        #1;
        read_word("mrst_mem", 18'h20, 1'b0, 1'b0);
        check_val("mrst_keep", ref_mem[10'h20], prev20);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            logic [17:0] ra;
            ra = {8'($urandom), 4'd0, 6'($urandom)};
            if ($urandom_range(0, 2) != 0) begin
                write_word(ra, 16'($urandom), 1'($urandom), 1'($urandom),
                           int'($urandom_range(1, 3)), 1'b0,
                           ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1));
            end
            if ($urandom_range(0, 1) == 1) begin
                read_word("rand_rd", ra, 1'($urandom), 1'($urandom));
            end else begin
                read_word("rand_rd", {12'($urandom), 6'($urandom)}, 1'b0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_emu_responder.md
Name: sram_emu_responder

Overview:
- Synthesizable responder for the SRAM side of the external asynchronous SRAM bus, using on-chip block RAM.
- It sits where the physical SRAM chip would be, on the ad/we_n/oe_n/ce_n/ub_n/lb_n/dio pins driven by the SRAM controller.
- It lets the controller and its test harness run on-chip with no external memory.
- All bus signals are sampled in the controller's clock domain: one clock, no synchronizers.

Parameters:
- ADDR_W, 10: implemented address bits; the memory holds 2^ADDR_W 16-bit words.
- DATA_W, 16: word width; must be 16 for byte-lane operation.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ad  in  18  SRAM word address; only ad[ADDR_W-1:0] is used.
- we_n  in  1  write enable, active low.
- oe_n  in  1  output enable, active low.
- ce_n  in  1  chip enable, active low.
- ub_n  in  1  upper byte lane enable, active low (dio[15:8]).
- lb_n  in  1  lower byte lane enable, active low (dio[7:0]).
- dio  inout  16  bidirectional data bus.
- wr_count  out  16  number of committed writes; wraps modulo 2^16.
- conflict  out  1  sticky flag: we_n, oe_n and ce_n were all low in the same sampled cycle.

Behaviour:
- Reset: one clock with reset_n low, applied mid-operation, must:
  - leave dio fully high-Z;
  - clear wr_count to 0 and conflict to 0;
  - return the FSM to IDLE and clear all input registers to inactive (strobes high);
  - discard any in-progress write without committing it.
  - Array contents are not cleared and are undefined after power-up.
- Input stage: ad, we_n, oe_n, ce_n, ub_n, lb_n and dio are registered every rising edge into _q copies. All decisions use the _q copies.
- FSM states are IDLE, WRITE and COMMIT.
  - IDLE -> WRITE when ce_q=0 and we_q=0.
  - WRITE, every cycle: latch addr_w=ad_q, data_w=din_q, ub_w=ub_q, lb_w=lb_q. The last sample taken while we_q=0 and ce_q=0 wins.
  - WRITE -> COMMIT when we_q=1 or ce_q=1 (trailing edge of the write pulse, as on a real SRAM).
  - COMMIT: write data_w into mem[addr_w] on the enabled lanes only. If both ub_w and lb_w are high, nothing is written and wr_count is not incremented; otherwise wr_count increments.
  - COMMIT -> WRITE if ce_q=0 and we_q=0 again, else COMMIT -> IDLE.
  - A single-cycle we_n low pulse is a legal write.
- Read path:
  - The RAM read port reads mem[ad_q[ADDR_W-1:0]] into rd_q each cycle.
  - Bypass: when COMMIT writes the same address in the same cycle, rd_q takes the new data, merged per lane.
  - dio[15:8] is driven with rd_q[15:8] when ce_q2=0, oe_q2=0, we_q2=1 and ub_q2=0; otherwise it is Z. dio[7:0] follows the same rule with lb_q2 and rd_q[7:0]. The _q2 signals are the enables delayed one further stage, aligned with rd_q.
  - Read latency: 2 clocks from address/oe_n/ce_n being stable at the pins to valid data on dio. Turnoff: 2 clocks after oe_n, ce_n or a lane enable rises.
- Write priority: whenever we_q=0, the dio drivers are disabled regardless of oe_n, so there is no contention with the controller.
- Conflict: set when ce_q=0, we_q=0 and oe_q=0 in the same cycle. It holds until reset. The write still proceeds.
- Addressing: bits ad[17:ADDR_W] are ignored, so addresses alias modulo 2^ADDR_W.
- Back-to-back writes with no IDLE cycle (WRITE->COMMIT->WRITE) are legal. Each write commits exactly once.

Test Plan:
- Single write: reset, then ce_n=0, lb_n=ub_n=0, ad=0x00012, dio=0xA55A, we_n low for 2 cycles then high. -> COMMIT one cycle later; wr_count=1; a subsequent read of 0x12 drives dio=0xA55A 2 clocks after oe_n falls.
- Byte lanes: write 0x1234 to 0x5, then write 0xFFFF to 0x5 with ub_n=1, lb_n=0. -> mem[5]=0x12FF. A read with ub_n=0, lb_n=1 gives dio[15:8]=0x12 with dio[7:0]=Z.
- Aliasing and bypass: write 0xBEEF to ad=0x00403 (ADDR_W=10) while oe_n=0 and we_n=1 on that address in the cycle after. -> read of ad=0x003 returns 0xBEEF with no stale 0x1234-style value on the first valid cycle.
- Back-to-back: three writes with we_n high for exactly one cycle between them, to addresses 1, 2, 3 with data 0x0001, 0x0002, 0x0003. -> wr_count=3 and all three read back correctly. Both lanes disabled on a fourth write -> wr_count stays 3.
- Conflict: ce_n=0, oe_n=0, we_n=0 together for 1 cycle with dio=0x7777 at ad=0x9. -> conflict=1 and sticky, dio never driven by the block, mem[9]=0x7777.
- Reset mid-write: assert reset_n=0 while in WRITE with dio=0xDEAD at ad=0x20. -> no commit, wr_count=0, dio=Z, FSM=IDLE; mem[0x20] keeps its previous value.
